// File: rtl/gp_fifo_pkg.sv
// Shared sizing and pointer helpers for the general-purpose FIFO family.
package gp_fifo_pkg;

    localparam int unsigned MIN_SLOTS = 2;

    function automatic int unsigned ptr_w(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned slots);
        return $clog2(slots + 1);
    endfunction

    // Explicit compare so depths that are not a power of two wrap correctly.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned slots);
        return (ptr >= slots - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/gp_fifo_wrap_ptr.sv
// Modulo-SLOTS pointer with enable and synchronous clear.
module gp_fifo_wrap_ptr
    import gp_fifo_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned PW    = ptr_w(SLOTS)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= PW'(wrap_inc(32'(ptr), SLOTS));
        end
    end

endmodule

// File: rtl/sync_gp_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty
// thresholds, FWFT or registered read, sync flush and sticky error flags.
module sync_gp_fifo
    import gp_fifo_pkg::*;
#(
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AFULL_TH  = SLOTS - 1,
    parameter int unsigned AEMPTY_TH = 1,
    parameter int unsigned FWFT      = 1
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       wr_full_o,
    output logic                       wr_afull_o,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic                       rd_empty_o,
    output logic                       rd_aempty_o,
    output logic [$clog2(SLOTS+1)-1:0] count_o,
    output logic                       ovf_o,
    output logic                       udf_o
);

    localparam int unsigned PW = ptr_w(SLOTS);
    localparam int unsigned CW = cnt_w(SLOTS);

    if (SLOTS < MIN_SLOTS) begin : g_bad_slots
        $error("sync_gp_fifo: SLOTS must be >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > SLOTS) begin : g_bad_afull
        $error("sync_gp_fifo: AFULL_TH must be in 1..SLOTS");
    end
    if (AEMPTY_TH > SLOTS - 1) begin : g_bad_aempty
        $error("sync_gp_fifo: AEMPTY_TH must be in 0..SLOTS-1");
    end

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             afull_q;
    logic             empty_q;
    logic             aempty_q;
    logic             ovf_q;
    logic             udf_q;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the flags registered at cycle start; flush overrides both.
    assign wr_acc = wr_en_i & ~full_q  & ~flush_i;
    assign rd_acc = rd_en_i & ~empty_q & ~flush_i;

    gp_fifo_wrap_ptr #(.SLOTS(SLOTS), .PW(PW)) u_wr_ptr (
        .clk  (clk),
        .arst (arst),
        .clr  (flush_i),
        .en   (wr_acc),
        .ptr  (wr_ptr)
    );

    gp_fifo_wrap_ptr #(.SLOTS(SLOTS), .PW(PW)) u_rd_ptr (
        .clk  (clk),
        .arst (arst),
        .clr  (flush_i),
        .en   (rd_acc),
        .ptr  (rd_ptr)
    );

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Flags are registered decodes of the next count so they track count_o exactly.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            full_q   <= (count_d == CW'(SLOTS));
            afull_q  <= (count_d >= CW'(AFULL_TH));
            empty_q  <= (count_d == '0);
            aempty_q <= (count_d <= CW'(AEMPTY_TH));
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en_i && full_q) begin
                ovf_q <= 1'b1;
            end
            if (rd_en_i && empty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data_o  = mem[rd_ptr];
        assign rd_valid_o = ~empty_q;
    end else begin : g_regrd
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        // Valid pulses for exactly the cycle after an accepted read.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (flush_i) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end

    assign wr_full_o   = full_q;
    assign wr_afull_o  = afull_q;
    assign rd_empty_o  = empty_q;
    assign rd_aempty_o = aempty_q;
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;

endmodule

// File: tb/tb_sync_gp_fifo.sv
// Bench for sync_gp_fifo: FWFT and registered-read instances share stimulus and
// are compared every cycle against a queue-based model of the FIFO.
module tb_sync_gp_fifo;

    localparam int unsigned SLOTS = 5;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             arst;
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;

    logic             full1, afull1, empty1, aempty1, valid1, ovf1, udf1;
    logic [WIDTH-1:0] data1;
    logic [2:0]       count1;
    logic             full0, afull0, empty0, aempty0, valid0, ovf0, udf0;
    logic [WIDTH-1:0] data0;
    logic [2:0]       count0;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic [WIDTH-1:0] q[$];
    logic             m_ovf;
    logic             m_udf;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               sz;

    always #5 clk = ~clk;

    sync_gp_fifo #(.SLOTS(SLOTS), .WIDTH(WIDTH), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(1)) dut (
        .clk(clk), .arst(arst), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_full_o(full1), .wr_afull_o(afull1), .rd_en_i(rd_en), .rd_data_o(data1),
        .rd_valid_o(valid1), .rd_empty_o(empty1), .rd_aempty_o(aempty1), .count_o(count1),
        .ovf_o(ovf1), .udf_o(udf1)
    );

    sync_gp_fifo #(.SLOTS(SLOTS), .WIDTH(WIDTH), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(0)) dut0 (
        .clk(clk), .arst(arst), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_full_o(full0), .wr_afull_o(afull0), .rd_en_i(rd_en), .rd_data_o(data0),
        .rd_valid_o(valid0), .rd_empty_o(empty0), .rd_aempty_o(aempty0), .count_o(count0),
        .ovf_o(ovf0), .udf_o(udf0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // One clock edge of FIFO behaviour, judged on occupancy at the start of the cycle.
    task automatic model_step();
        int n;
        n = q.size();
        if (arst) begin
            model_reset();
        end else if (flush) begin
            q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (rd_en) begin
                if (n == 0) begin
                    m_udf = 1'b1;
                end else begin
                    m_data  = q.pop_front();
                    m_valid = 1'b1;
                end
            end
            if (wr_en) begin
                if (n == int'(SLOTS)) m_ovf = 1'b1;
                else                  q.push_back(wr_data);
            end
        end
    endtask

    task automatic cyc(input logic f, input logic w, input logic [WIDTH-1:0] d, input logic r);
        flush   = f;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        model_step();
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            sz = q.size();
            chk("count",    32'(count1), 32'(sz));
            chk("count0",   32'(count0), 32'(sz));
            chk("full",     32'(full1),  32'(sz == int'(SLOTS)));
            chk("afull",    32'(afull1), 32'(sz >= 4));
            chk("empty",    32'(empty1), 32'(sz == 0));
            chk("aempty",   32'(aempty1), 32'(sz <= 1));
            chk("flags0",   {28'd0, full0, afull0, empty0, aempty0},
                {28'd0, sz == int'(SLOTS), sz >= 4, sz == 0, sz <= 1});
            chk("ovf",      {30'd0, ovf1, ovf0}, {30'd0, m_ovf, m_ovf});
            chk("udf",      {30'd0, udf1, udf0}, {30'd0, m_udf, m_udf});
            chk("fwft_valid", 32'(valid1), 32'(sz != 0));
            if (sz != 0) chk("fwft_head", 32'(data1), 32'(q[0]));
            chk("reg_valid", 32'(valid0), 32'(m_valid));
            chk("reg_data",  32'(data0),  32'(m_data));
        end
    end

    initial begin
        arst    = 1'b1;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count1), 32'd0);
        chk("rst_empty", {28'd0, empty1, aempty1, full1, afull1}, 32'b1100);
        chk("rst_err",   {28'd0, ovf1, udf1, ovf0, udf0}, 32'd0);
        chk("rst_valid", {30'd0, valid1, valid0}, 32'd0);
        chk("rst_data0", 32'(data0), 32'd0);
        arst   = 1'b0;
        chk_en = 1'b1;

        // Fill to full, overflow once, then drain in order.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
            chk("fill_count", 32'(count1), 32'(i + 1));
            chk("fill_afull", 32'(afull1), 32'(i + 1 >= 4));
            chk("fill_full",  32'(full1),  32'(i + 1 == 5));
        end
        cyc(1'b0, 1'b1, 8'h99, 1'b0);
        chk("ovf_set",    32'(ovf1),   32'd1);
        chk("ovf_count",  32'(count1), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("drain_head", 32'(data1), 32'(8'h10 + i));
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_data0", {23'd0, valid0, data0}, {23'd0, 1'b1, 8'(8'h10 + i)});
        end
        chk("drain_empty", {30'd0, empty1, udf1}, 32'b10);

        // Pointer wrap with interleaved traffic.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_rd", 32'(data0), 32'(8'h20 + i));
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_il", 32'(data0), 32'(8'h40 + i));
        end

        // Full with simultaneous write/read, then empty with simultaneous write/read.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        cyc(1'b0, 1'b1, 8'hEE, 1'b1);
        chk("fullrw_count", 32'(count1), 32'd4);
        chk("fullrw_ovf",   32'(ovf1),   32'd1);
        chk("fullrw_data",  32'(data0),  32'h30);
        for (int i = 1; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drained_data", 32'(data0), 32'h34);
        cyc(1'b0, 1'b1, 8'h77, 1'b1);
        chk("emptyrw_count", 32'(count1), 32'd1);
        chk("emptyrw_udf",   32'(udf1),   32'd1);
        chk("emptyrw_valid", 32'(valid0), 32'd0);

        // Flush at count 3 with a write in the same cycle.
        cyc(1'b0, 1'b1, 8'h78, 1'b0);
        cyc(1'b0, 1'b1, 8'h79, 1'b0);
        chk("preflush_count", 32'(count1), 32'd3);
        cyc(1'b1, 1'b1, 8'h55, 1'b0);
        chk("flush_state", {27'd0, count1, empty1, ovf1, udf1}, {27'd0, 3'd0, 1'b1, 1'b0, 1'b0});
        chk("flush_data0", 32'(data0), 32'h34);

        // Registered-read latency.
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("a5_novalid", 32'(valid0), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("a5_read", {23'd0, valid0, data0}, {23'd0, 1'b1, 8'hA5});
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("a5_hold", {23'd0, valid0, data0}, {23'd0, 1'b0, 8'hA5});

        // Asynchronous reset mid-operation.
        cyc(1'b0, 1'b1, 8'h01, 1'b0);
        cyc(1'b0, 1'b1, 8'h02, 1'b0);
        chk("prearst_count", 32'(count1), 32'd2);
        arst = 1'b1;
        #2;
        model_reset();
        chk("arst_count", 32'(count1), 32'd0);
        chk("arst_flags", {28'd0, empty1, aempty1, full1, afull1}, 32'b1100);
        chk("arst_data0", 32'(data0), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        arst = 1'b0;
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("post_head", {23'd0, valid1, data1}, {23'd0, 1'b1, 8'h3C});
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_read", {23'd0, valid0, data0}, {23'd0, 1'b1, 8'h3C});

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(1'b0 | ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                8'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
